abc_record_unpacker: RTL

Streaming deconstructor for the nested record type `abc_t` = {A, BC1{B,C}, BC2{B,C}}. It is the inverse of the assignment-pattern construction of that record. It accepts one fully packed record per handshake and emits its fields one per beat, in declaration order, each tagged with the member it came from. A record whose five members are all equal can optionally collapse to a single "default" beat, mirroring `'{default:v}`. It sits between a packed-record producer and any field-serial consumer, such as a trace writer or a register-file loader.

---
 rtl/abc_pkg.sv | 44 ++++
 rtl/abc_record_unpacker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/abc_pkg.sv
// abc_pkg
// Shared types for the nested record abc_t = {A, BC1{B,C}, BC2{B,C}}.
//   abc_bc_t       : packed {b, c} pair
//   abc_t          : packed {a, bc1, bc2}; a sits in the MSBs
//   abc_tag_e      : member tag carried with every emitted field beat
//   abc_state_e    : unpacker FSM states
//   abc_is_default : true when all five members of a record are equal
package abc_pkg;

  localparam int ABC_W          = 32;
  localparam int ABC_NUM_FIELDS = 5;

  typedef struct packed {
    logic [ABC_W-1:0] b;
    logic [ABC_W-1:0] c;
  } abc_bc_t;

  typedef struct packed {
    logic [ABC_W-1:0] a;
    abc_bc_t          bc1;
    abc_bc_t          bc2;
  } abc_t;

  typedef enum logic [2:0] {
    TAG_A       = 3'd0,
    TAG_BC1_B   = 3'd1,
    TAG_BC1_C   = 3'd2,
    TAG_BC2_B   = 3'd3,
    TAG_BC2_C   = 3'd4,
    TAG_DEFAULT = 3'd7
  } abc_tag_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } abc_state_e;

  // A record built as '{default:v} has every scalar member equal to v.
  function automatic logic abc_is_default(input abc_t rec);
    return (rec.a == rec.bc1.b) && (rec.a == rec.bc1.c) &&
           (rec.a == rec.bc2.b) && (rec.a == rec.bc2.c);
  endfunction

endpackage

// File: rtl/abc_record_unpacker.sv
// abc_record_unpacker
// Takes one packed abc_t per input handshake and replays its members one
// beat at a time in declaration order (A, BC1.B, BC1.C, BC2.B, BC2.C), each
// tagged with its member. An all-equal record may collapse to a single
// TAG_DEFAULT beat when COMPRESS_DEFAULT is set.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   record handshake
//   in_data  [5*W]        packed record, A in the MSBs, BC2.C in the LSBs
//   out_valid / out_ready field beat handshake
//   out_tag  [3]          abc_tag_e of the current beat
//   out_data [W]          field value
//   out_last              final beat of the current record
//   rec_count [16]        records fully emitted, wrapping
module abc_record_unpacker
  import abc_pkg::*;
#(
  parameter int W                = 32,
  parameter bit COMPRESS_DEFAULT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [5*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2:0]     out_tag,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [15:0]    rec_count
);

  abc_state_e     state_q, state_d;
  logic [5*W-1:0] rec_q;
  logic [2:0]     idx_q;
  logic           dflt_q;
  logic           rec_count_en;

  logic [W-1:0]   field_data;
  abc_tag_e       field_tag;
  logic           last_beat;
  logic           in_all_equal;
  logic           accept;
  logic           beat_taken;

  // Exact equality of all five W-bit members; no partial compression.
  always_comb begin
    in_all_equal = 1'b1;
    for (int i = 1; i < ABC_NUM_FIELDS; i++) begin
      if (in_data[i*W +: W] != in_data[0 +: W]) begin
        in_all_equal = 1'b0;
      end
    end
  end

  // Member i lives at slot (4-i) counting up from the LSBs.
  always_comb begin
    field_data = '0;
    field_tag  = TAG_A;
    case (idx_q)
      3'd0: begin field_data = rec_q[4*W +: W]; field_tag = TAG_A;     end
      3'd1: begin field_data = rec_q[3*W +: W]; field_tag = TAG_BC1_B; end
      3'd2: begin field_data = rec_q[2*W +: W]; field_tag = TAG_BC1_C; end
      3'd3: begin field_data = rec_q[1*W +: W]; field_tag = TAG_BC2_B; end
      3'd4: begin field_data = rec_q[0*W +: W]; field_tag = TAG_BC2_C; end
      default: begin field_data = '0; field_tag = TAG_A; end
    endcase
  end

  // Outputs are zero whenever no beat is offered. in_ready also opens during
  // the last-beat handshake so back-to-back records stream without a bubble;
  // it depends only on state and out_ready, never on in_valid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_tag   = 3'd0;
    out_data  = '0;
    last_beat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (dflt_q) begin
          out_tag   = TAG_DEFAULT;
          out_data  = rec_q[4*W +: W];
          last_beat = 1'b1;
        end else begin
          out_tag   = field_tag;
          out_data  = field_data;
          last_beat = (idx_q == 3'(ABC_NUM_FIELDS - 1));
        end
        if (out_ready && last_beat) begin
          in_ready = 1'b1;
          state_d  = in_valid ? ST_EMIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_last     = last_beat;
  assign accept       = in_valid && in_ready;
  assign beat_taken   = out_valid && out_ready;
  assign rec_count_en = beat_taken && last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fresh capture takes priority over advancing idx_q; the two only
  // coincide on a last beat, where idx_q must restart at 0 anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q     <= '0;
      idx_q     <= 3'd0;
      dflt_q    <= 1'b0;
      rec_count <= 16'd0;
    end else begin
      if (accept) begin
        rec_q  <= in_data;
        idx_q  <= 3'd0;
        dflt_q <= COMPRESS_DEFAULT ? in_all_equal : 1'b0;
      end else if (beat_taken && !last_beat) begin
        idx_q <= idx_q + 3'd1;
      end
      if (rec_count_en) begin
        rec_count <= rec_count + 16'd1;
      end
    end
  end

endmodule
